// File: rtl/spart_rx.sv
// spart_rx: receive half of the SPART.
// Deserialises the asynchronous rxd line with OVERSAMPLE ticks per bit.
// Frame: start(0), DATA_BITS data bits LSB first, optional parity, stop(1).
// The received word and its status are held until the bus interface reads them.
// Optional feature: define PARITY_EN to add an even-parity bit between data and stop.
module spart_rx #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_enable,
  input  logic                 rxd,
  input  logic                 rd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rda,
  output logic                 framing_err,
  output logic                 overrun,
  output logic                 parity_err
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int IW = $clog2(DATA_BITS);

  localparam logic [CW-1:0] MID_START = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] MID_BIT   = CW'(OVERSAMPLE - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(DATA_BITS - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] STOP   = 3'd3;
`ifdef PARITY_EN
  localparam logic [2:0] PARITY = 3'd4;
`endif

  logic                 sync_p0;
  logic                 sync_p1;
  logic [2:0]           state;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        idx;
  logic [DATA_BITS-1:0] shreg;
`ifdef PARITY_EN
  logic                 par_bit;
  logic                 parity_r;
`endif

  // Two-flop synchroniser; idles high so reset does not look like a start edge
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
    end else begin
      sync_p0 <= rxd;
      sync_p1 <= sync_p0;
    end
  end

  // Receive FSM, shift register and status registers (a load overrides a read clear)
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      shreg       <= '0;
      rx_data     <= '0;
      rda         <= 1'b0;
      framing_err <= 1'b0;
      overrun     <= 1'b0;
`ifdef PARITY_EN
      par_bit     <= 1'b0;
      parity_r    <= 1'b0;
`endif
    end else begin
      if (rd) begin
        rda         <= 1'b0;
        framing_err <= 1'b0;
        overrun     <= 1'b0;
`ifdef PARITY_EN
        parity_r    <= 1'b0;
`endif
      end
      if (rx_enable) begin
        case (state)
          IDLE: begin
            if (!sync_p1) begin
              state <= START;
              cnt   <= '0;
            end
          end
          START: begin
            cnt <= cnt + 1'b1;
            if (cnt == MID_START) begin
              if (sync_p1) begin
                // line went back high before mid-start: treat as a glitch
                state <= IDLE;
              end else begin
                state <= DATA;
                cnt   <= '0;
                idx   <= '0;
              end
            end
          end
          DATA: begin
            cnt <= cnt + 1'b1;
            if (cnt == MID_BIT) begin
              shreg <= {sync_p1, shreg[DATA_BITS-1:1]};
              idx   <= idx + 1'b1;
              if (idx == LAST_IDX) begin
`ifdef PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
                cnt   <= '0;
              end
            end
          end
`ifdef PARITY_EN
          PARITY: begin
            cnt <= cnt + 1'b1;
            if (cnt == MID_BIT) begin
              par_bit <= sync_p1;
              state   <= STOP;
              cnt     <= '0;
            end
          end
`endif
          STOP: begin
            cnt <= cnt + 1'b1;
            if (cnt == MID_BIT) begin
              // load at mid-stop so IDLE is ready for an immediately following start edge
              rx_data     <= shreg;
              framing_err <= ~sync_p1;
              overrun     <= rda & ~rd;
              rda         <= 1'b1;
`ifdef PARITY_EN
              parity_r    <= (^shreg) ^ par_bit;
`endif
              state       <= IDLE;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

`ifdef PARITY_EN
  assign parity_err = parity_r;
`else
  assign parity_err = 1'b0;
`endif

endmodule
